noc_port_arbiter: RTL

Round-robin output-port arbiter for the minimal NoC router. It shares one output link among `N_REQ` input FIFOs and pops flits from the granted FIFO. It registers each flit into a one-entry output stage with valid/ready handshake. A grant is held for a whole packet, until a tail flit or watchdog release, so packets never interleave on the link.

---
 rtl/noc_port_arbiter_if.sv | 24 ++
 rtl/noc_port_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/noc_port_arbiter_if.sv
// Link-side bundle for noc_port_arbiter: input FIFO heads, pop strobes, output flit.
// Ports: req_empty/req_data/req_read_en toward the N_REQ input FIFOs,
//        out_data/out_valid/out_ready toward the shared output link.
interface noc_port_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DEPTH = 32
) ();
  logic [N_REQ-1:0]       req_empty;
  logic [N_REQ*DEPTH-1:0] req_data;
  logic [N_REQ-1:0]       req_read_en;
  logic [DEPTH-1:0]       out_data;
  logic                   out_valid;
  logic                   out_ready;

  // master: the arbiter side; slave: FIFOs plus downstream link
  modport master (
    input  req_empty, req_data, out_ready,
    output req_read_en, out_data, out_valid
  );
  modport slave (
    output req_empty, req_data, out_ready,
    input  req_read_en, out_data, out_valid
  );
endinterface

// File: rtl/noc_port_arbiter.sv
// Round-robin output-port arbiter: grants one input FIFO per packet, pops it into a
// one-entry registered output stage; latency 1 cycle arbitration + 1 cycle to out_valid.
// Backpressure: no pop while out_valid & ~out_ready; pop allowed in the cycle ready rises.
// Ports: clk, reset (sync, active-high), bus (master modport: FIFO heads, pop strobes,
//        output flit handshake), grant (one-hot owner), busy (LOCK), err (watchdog pulse).
module noc_port_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DEPTH     = 32,
  parameter int MAX_FLITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  noc_port_arbiter_if.master   bus,
  output logic [N_REQ-1:0]     grant,
  output logic                 busy,
  output logic                 err
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_FLITS + 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t              state_q;
  logic [IW-1:0]       owner_q;
  logic [IW-1:0]       rr_ptr_q;
  logic [CW-1:0]       flit_cnt_q;
  logic [N_REQ-1:0]    grant_q;
  logic                busy_q;
  logic                err_q;
  logic                out_valid_q;
  logic [DEPTH-1:0]    out_data_q;

  logic                arb_hit;
  logic [IW-1:0]       arb_idx;
  logic [DEPTH-1:0]    owner_data;
  logic                pop;
  logic                is_tail;
  logic                wd_hit;
  logic [IW-1:0]       owner_next;

  // base + k with an explicit single wrap; both operands are < N_REQ so one
  // subtraction is a true mod and works for non-power-of-2 N_REQ.
  function automatic logic [IW-1:0] scan_idx(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return IW'(s);
  endfunction

  // Walk from the farthest candidate back to rr_ptr so the closest requester wins.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (!bus.req_empty[scan_idx(rr_ptr_q, k)]) begin
        arb_hit = 1'b1;
        arb_idx = scan_idx(rr_ptr_q, k);
      end
    end
  end

  assign owner_data = bus.req_data[int'(owner_q)*DEPTH +: DEPTH];
  assign is_tail    = owner_data[DEPTH-1];
  assign wd_hit     = (flit_cnt_q == CW'(MAX_FLITS - 1));
  assign owner_next = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

  // Reset gates the pop: a flit popped in a reset cycle would be lost because
  // the output stage is cleared on the same edge.
  assign pop = ~reset & (state_q == LOCK) & ~bus.req_empty[owner_q]
             & (~out_valid_q | bus.out_ready);

  always_comb begin
    bus.req_read_en          = '0;
    bus.req_read_en[owner_q] = pop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      flit_cnt_q  <= '0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Output stage keeps draining while we arbitrate.
          if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
          if (arb_hit) begin
            state_q <= LOCK;
            owner_q <= arb_idx;
            grant_q <= N_REQ'(1) << arb_idx;
            busy_q  <= 1'b1;
          end
        end
        LOCK: begin
          if (pop) begin
            out_data_q  <= owner_data;
            out_valid_q <= 1'b1;
            flit_cnt_q  <= flit_cnt_q + 1'b1;
            if (is_tail || wd_hit) begin
              state_q    <= IDLE;
              grant_q    <= '0;
              busy_q     <= 1'b0;
              flit_cnt_q <= '0;
              rr_ptr_q   <= owner_next;
              err_q      <= ~is_tail;
            end
          end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
          // Owner empty with no pop: hold the grant, never switch mid-packet.
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant         = grant_q;
  assign busy          = busy_q;
  assign err           = err_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
endmodule
